// File: rtl/mc_biquad_pkg.sv
// Shared types and helpers for the multi-channel biquad band-pass.
// Holds widths, the FSM state enum and the round/saturate helper.
package mc_biquad_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int COEF_W_DEF = 18;
  localparam int FRAC_DEF   = 14;

  function automatic int acc_w(input int dw, input int cw);
    return dw + cw + 3;
  endfunction

  localparam int ACC_W = acc_w(DATA_W_DEF, COEF_W_DEF);

  function automatic int ch_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  typedef enum logic [2:0] {
    IDLE,
    MAC0,
    MAC1,
    MAC2,
    OUT
  } state_t;

  typedef struct packed {
    logic               sat;
    logic signed [31:0] data;
  } sr_t;

  // Round half up by 2^(frac-1), shift by frac, clamp to dw signed bits.
  function automatic sr_t sat_round(
    input logic signed [63:0] acc,
    input int                 frac,
    input int                 dw
  );
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sr_t                s;
    r  = (acc + (64'sd1 <<< (frac - 1))) >>> frac;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    s.sat  = 1'b0;
    s.data = 32'(r);
    if (r > hi) begin
      s.sat  = 1'b1;
      s.data = 32'(hi);
    end else if (r < lo) begin
      s.sat  = 1'b1;
      s.data = 32'(lo);
    end
    return s;
  endfunction

endpackage

// File: rtl/biquad_state_ram.sv
// Per-channel delay state {x1,x2,y1,y2}, register based.
// Ports: sync write (we/wch/wdata), comb read (rch/rdata), sync clr.
module biquad_state_ram #(
  parameter int DATA_W   = 16,
  parameter int CHANNELS = 4,
  parameter int CH_W     = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                we,
  input  logic [CH_W-1:0]     wch,
  input  logic [4*DATA_W-1:0] wdata,
  input  logic [CH_W-1:0]     rch,
  output logic [4*DATA_W-1:0] rdata
);

  logic [4*DATA_W-1:0] mem [CHANNELS];

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      for (int i = 0; i < CHANNELS; i++) begin
        mem[i] <= '0;
      end
    end else if (we && (int'(wch) < CHANNELS)) begin
      mem[wch] <= wdata;
    end
  end

  // Out-of-range channels read as zero state.
  always_comb begin
    rdata = '0;
    if (int'(rch) < CHANNELS) begin
      rdata = mem[rch];
    end
  end

endmodule

// File: rtl/mc_biquad_bandpass.sv
// Multi-channel DF-I band-pass biquad, one shared MAC, 5-clock schedule.
// In: valid/ready sample stream + coeffs; out: valid/ready y[n] + sat.
module mc_biquad_bandpass
  import mc_biquad_pkg::*;
#(
  parameter int  DATA_W   = 16,
  parameter int  COEF_W   = 18,
  parameter int  FRAC     = 14,
  parameter int  CHANNELS = 4,
  localparam int CH_W     = ch_w(CHANNELS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CH_W-1:0]          in_ch,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic signed [COEF_W-1:0] b0,
  input  logic signed [COEF_W-1:0] a1,
  input  logic signed [COEF_W-1:0] a2,
  input  logic                     bypass,
  input  logic                     clr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CH_W-1:0]          out_ch,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     sat
);

  localparam int AW = acc_w(DATA_W, COEF_W);
  localparam int PW = DATA_W + 1 + COEF_W;

  state_t state, nxt;

  logic [CH_W-1:0]          ch_r;
  logic signed [DATA_W-1:0] x_r;
  logic signed [COEF_W-1:0] b0_r, a1_r, a2_r;
  logic                     byp_r;
  logic                     drop_r;
  logic signed [AW-1:0]     acc;

  logic [4*DATA_W-1:0]      rd, wd;
  logic signed [DATA_W-1:0] x1, x2, y1, y2;
  logic signed [COEF_W-1:0] coef;
  logic signed [DATA_W:0]   opnd;
  logic signed [PW-1:0]     prod;
  logic signed [AW-1:0]     prod_x, sum;
  sr_t                      sr;
  logic signed [DATA_W-1:0] y;
  logic                     y_sat;
  logic                     take, we;

  assign {x1, x2, y1, y2} = rd;

  assign in_ready  = (state == IDLE) && rst_n && !clr;
  assign take      = in_valid && in_ready;
  assign out_valid = (state == OUT);

  // Single multiplier; operands steered by the MAC phase.
  always_comb begin
    coef = b0_r;
    opnd = {x_r[DATA_W-1], x_r} - {x2[DATA_W-1], x2};
    unique case (state)
      MAC1: begin
        coef = a1_r;
        opnd = {y1[DATA_W-1], y1};
      end
      MAC2: begin
        coef = a2_r;
        opnd = {y2[DATA_W-1], y2};
      end
      default: ;
    endcase
  end

  assign prod   = coef * opnd;
  assign prod_x = AW'(prod);
  assign sum    = acc - prod_x;

  always_comb begin
    sr    = sat_round(64'(sum), FRAC, DATA_W);
    y     = byp_r ? x_r : sr.data[DATA_W-1:0];
    y_sat = !byp_r && sr.sat;
  end

  assign we = (state == MAC2) && !drop_r && !clr;
  assign wd = {x_r, x1, y, y1};

  biquad_state_ram #(
    .DATA_W   (DATA_W),
    .CHANNELS (CHANNELS),
    .CH_W     (CH_W)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .we    (we),
    .wch   (ch_r),
    .wdata (wd),
    .rch   (ch_r),
    .rdata (rd)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (take) nxt = MAC0;
      MAC0: nxt = MAC1;
      MAC1: nxt = MAC2;
      MAC2: nxt = drop_r ? IDLE : OUT;
      OUT:  if (out_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
    if (clr) nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ch_r     <= '0;
      x_r      <= '0;
      b0_r     <= '0;
      a1_r     <= '0;
      a2_r     <= '0;
      byp_r    <= 1'b0;
      drop_r   <= 1'b0;
      acc      <= '0;
      out_ch   <= '0;
      out_data <= '0;
      sat      <= 1'b0;
    end else begin
      if (take) begin
        ch_r   <= in_ch;
        x_r    <= in_data;
        b0_r   <= b0;
        a1_r   <= a1;
        a2_r   <= a2;
        byp_r  <= bypass;
        drop_r <= int'(in_ch) >= CHANNELS;
      end
      unique case (state)
        MAC0:       acc <= prod_x;
        MAC1, MAC2: acc <= sum;
        default: ;
      endcase
      if (we) begin
        out_ch   <= ch_r;
        out_data <= y;
        sat      <= y_sat;
      end
    end
  end

endmodule

// File: tb/tb_mc_biquad_bandpass.sv
// Scoreboard bench for mc_biquad_bandpass.
// Drives samples, predicts y[n] with a behavioural model, checks outputs.
module tb_mc_biquad_bandpass;

  localparam int CH = 4;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic [1:0]         in_ch;
  logic signed [15:0] in_data;
  logic signed [17:0] b0, a1, a2;
  logic               bypass;
  logic               clr;
  logic               out_valid;
  logic               out_ready;
  logic [1:0]         out_ch;
  logic signed [15:0] out_data;
  logic               sat;

  always #5 clk = ~clk;

  mc_biquad_bandpass #(.CHANNELS(CH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ch     (in_ch),
    .in_data   (in_data),
    .b0        (b0),
    .a1        (a1),
    .a2        (a2),
    .bypass    (bypass),
    .clr       (clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ch    (out_ch),
    .out_data  (out_data),
    .sat       (sat)
  );

  typedef struct {
    int ch;
    int data;
    int sat;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   mx1[CH], mx2[CH], my1[CH], my2[CH];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  function automatic void model_zero();
    for (int i = 0; i < CH; i++) begin
      mx1[i] = 0; mx2[i] = 0; my1[i] = 0; my2[i] = 0;
    end
  endfunction

  function automatic void model(input int ch, input int x, input bit byp);
    longint acc, r;
    int     y, s;
    acc = longint'(b0) * longint'(x - mx2[ch])
        - longint'(a1) * longint'(my1[ch])
        - longint'(a2) * longint'(my2[ch]);
    r = (acc + 64'sd8192) >>> 14;
    s = 0;
    if (r > 32767) begin r = 32767; s = 1; end
    else if (r < -32768) begin r = -32768; s = 1; end
    y = int'(r);
    if (byp) begin y = x; s = 0; end
    mx2[ch] = mx1[ch]; mx1[ch] = x;
    my2[ch] = my1[ch]; my1[ch] = y;
    q.push_back('{ch, y, s});
  endfunction

  task automatic send(input int ch, input int x, input bit byp);
    int n;
    @(posedge clk); #1;
    in_ch = 2'(ch); in_data = 16'(x); bypass = byp; in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk); n++;
    end while (!in_ready && n < 300);
    if (!in_ready) begin
      chk("accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    model(ch, x, byp);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || !in_ready) && n < 300) begin
      @(negedge clk); n++;
    end
    chk("drain", q.size(), 0);
  endtask

  task automatic clear();
    @(posedge clk); #1;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    model_zero();
    q.delete();
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("spurious_out", 1, 0);
      end else begin
        mon_e = q.pop_front();
        chk("out_ch", out_ch, mon_e.ch);
        chk("out_data", out_data, mon_e.data);
        chk("out_sat", sat, mon_e.sat);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n = 1'b0; in_valid = 1'b0; in_ch = '0; in_data = '0;
    b0 = 18'sd1638; a1 = -18'sd26214; a2 = 18'sd13107;
    bypass = 1'b0; clr = 1'b0; out_ready = 1'b1;
    model_zero();

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_sat", sat, 0);
    chk("rst_out_ch", out_ch, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Impulse on ch0 with latency check on the first sample.
    send(0, 1000, 0);
    repeat (3) begin
      @(negedge clk);
      chk("lat_early", out_valid, 0);
    end
    @(negedge clk);
    chk("lat_valid", out_valid, 1);
    for (int i = 0; i < 7; i++) send(0, 0, 0);
    drain();

    // Interleaved ch0 impulse and ch2 zeros; coeff change mid-flight.
    clear();
    for (int i = 0; i < 6; i++) begin
      send(0, (i == 0) ? 1000 : 0, 0);
      b0 = 18'sd9999;
      @(posedge clk);
      b0 = 18'sd1638;
      send(2, 0, 0);
    end
    drain();

    // Saturation in both directions on ch1.
    clear();
    b0 = 18'sd32604; a1 = '0; a2 = '0;
    send(1, 32767, 0);
    send(1, -32767, 0);
    drain();
    b0 = 18'sd1638; a1 = -18'sd26214; a2 = 18'sd13107;

    // Backpressure on ch3.
    clear();
    out_ready = 1'b0;
    send(3, 1000, 0);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk); n++;
    end
    chk("bp_valid", out_valid, 1);
    fork
      send(3, 0, 0);
      begin
        repeat (10) begin
          @(negedge clk);
          chk("bp_hold_data", out_data, (q.size() > 0) ? q[0].data : -99999);
          chk("bp_in_ready", in_ready, 0);
        end
        @(posedge clk); #1 out_ready = 1'b1;
      end
    join
    send(3, 0, 0);
    drain();

    // clr during MAC1 discards the sample and zeroes state.
    clear();
    send(0, 1000, 0);
    @(posedge clk); #1;
    clr = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b1; in_ch = 2'd0; in_data = 16'sd555;
    @(negedge clk);
    chk("clr_in_ready", in_ready, 0);
    @(posedge clk); #1;
    clr = 1'b0; in_valid = 1'b0;
    model_zero();
    q.delete();
    repeat (6) begin
      @(negedge clk);
      chk("clr_no_out", out_valid, 0);
    end
    send(0, 1000, 0);
    for (int i = 0; i < 3; i++) send(0, 0, 0);
    drain();

    // Bypass then normal operation from the bypassed state.
    clear();
    send(0, 1234, 1);
    send(0, 0, 0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
